// File: rtl/che_hist_clr.sv
// che_hist_clr -- histogram-bank clear scheduler for the CLAHE engine.
//
// This block zeroes one of the three tile-histogram banks. It sweeps every
// tile/bin address, with bin as the inner loop and tile as the outer loop. It
// shares the single bank write port with the statistics accumulate path.
// Accumulate writes always win the port. The sweep address counter holds in
// any cycle where wr_req_i is high.
//
// A request that arrives while a sweep is running is parked in a one-entry
// pending slot. A second request in that situation is dropped and flags err_o.
// err_o is sticky until rst.
//
// Optional feature, selected by the macro CHE_HIST_CLR_STALL_CNT_EN:
//   defined   - stall_cnt_o counts CLR cycles blocked by accumulate traffic.
//               The count saturates at 16'hFFFF and restarts at each sweep.
//   undefined - stall_cnt_o is tied to zero and no counter is built.
module che_hist_clr #(
   parameter int GRAY_LVL_WD = 8,
   parameter int TILE_X_NUM  = 8,
   parameter int HIST_WD     = 12,
   localparam int TILE_WD    = (TILE_X_NUM > 1) ? $clog2(TILE_X_NUM) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   // clear request side (CLAHE control)
   input  logic                   clr_req_i,
   input  logic [1:0]             clr_num_i,
   output logic                   clr_busy_o,
   output logic                   clr_done_o,
   // accumulate write side (statistics path)
   input  logic                   wr_req_i,
   input  logic [1:0]             wr_num_i,
   input  logic [TILE_WD-1:0]     wr_tile_i,
   input  logic [GRAY_LVL_WD-1:0] wr_bin_i,
   input  logic [HIST_WD-1:0]     wr_dat_i,
   // histogram memory write port
   output logic                   mem_wr_en_o,
   output logic [1:0]             mem_wr_num_o,
   output logic [TILE_WD-1:0]     mem_wr_tile_o,
   output logic [GRAY_LVL_WD-1:0] mem_wr_bin_o,
   output logic [HIST_WD-1:0]     mem_wr_dat_o,
   // status
   output logic                   err_o,
   output logic [15:0]            stall_cnt_o
);

   localparam logic [TILE_WD-1:0]     TILE_LAST = TILE_WD'(TILE_X_NUM - 1);
   localparam logic [GRAY_LVL_WD-1:0] BIN_LAST  = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // FSM and sweep state
   state_t                 r_state;
   logic [1:0]             r_act_num;
   logic                   r_pend_vld;
   logic [1:0]             r_pend_num;
   logic [TILE_WD-1:0]     r_tile_cnt;
   logic [GRAY_LVL_WD-1:0] r_bin_cnt;
   logic                   r_done;
   logic                   r_err;

   // registered write port
   logic                   r_mem_en;
   logic [1:0]             r_mem_num;
   logic [TILE_WD-1:0]     r_mem_tile;
   logic [GRAY_LVL_WD-1:0] r_mem_bin;
   logic [HIST_WD-1:0]     r_mem_dat;

   // decoded control
   logic       w_req_ok;
   logic       w_req_bad;
   logic       w_issue;
   logic       w_conflict;
   logic       w_pend_take;
   logic       w_pend_store;
   logic       w_drop;
   logic       w_start;
   logic [1:0] w_start_num;

   // Only banks 0..2 exist; bank 3 is an illegal request.
   assign w_req_ok  = clr_req_i && (clr_num_i != 2'd3);
   assign w_req_bad = clr_req_i && (clr_num_i == 2'd3);

   // The sweep only owns the port when the statistics path is quiet.
   assign w_issue    = (r_state == ST_CLR) && !wr_req_i;
   assign w_conflict = (r_state == ST_CLR) && wr_req_i && (wr_num_i == r_act_num);

   // The pending entry is consumed whenever the FSM is free to start a sweep.
   assign w_pend_take = r_pend_vld && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   // A sweep starts from IDLE on a pending entry or a fresh request. It starts
   // from DONE only on a pending entry. A fresh request in DONE is parked first.
   assign w_start = ((r_state == ST_IDLE) && (r_pend_vld || w_req_ok)) ||
                    ((r_state == ST_DONE) && r_pend_vld);
   assign w_start_num = r_pend_vld ? r_pend_num : clr_num_i;

   // A fresh request is parked in the pending slot when it cannot go straight
   // into the active bank. The slot must be empty or being vacated this cycle.
   assign w_pend_store = w_req_ok && ((r_state != ST_IDLE) || r_pend_vld) &&
                         (!r_pend_vld || w_pend_take);
   assign w_drop       = w_req_ok && r_pend_vld && !w_pend_take;

   // Sweep FSM: walks the address counter and raises the done pulse after DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_act_num  <= 2'd0;
         r_tile_cnt <= '0;
         r_bin_cnt  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= (r_state == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state    <= ST_CLR;
                  r_act_num  <= w_start_num;
                  r_tile_cnt <= '0;
                  r_bin_cnt  <= '0;
               end
            end
            ST_CLR: begin
               if (w_issue) begin
                  if (r_bin_cnt == BIN_LAST) begin
                     r_bin_cnt <= '0;
                     if (r_tile_cnt == TILE_LAST) begin
                        r_tile_cnt <= '0;
                        r_state    <= ST_DONE;
                     end else begin
                        r_tile_cnt <= r_tile_cnt + TILE_WD'(1);
                     end
                  end else begin
                     r_bin_cnt <= r_bin_cnt + GRAY_LVL_WD'(1);
                  end
               end
            end
            ST_DONE: begin
               if (w_start) begin
                  r_state    <= ST_CLR;
                  r_act_num  <= w_start_num;
                  r_tile_cnt <= '0;
                  r_bin_cnt  <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // One-entry pending slot. A new request may refill the slot in the same
   // cycle that its previous entry is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_vld <= 1'b0;
         r_pend_num <= 2'd0;
      end else if (w_pend_store) begin
         r_pend_vld <= 1'b1;
         r_pend_num <= clr_num_i;
      end else if (w_pend_take) begin
         r_pend_vld <= 1'b0;
      end
   end

   // Sticky error: illegal bank, overflowed pending slot, or an accumulate
   // write hitting the bank being cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_req_bad || w_drop || w_conflict) begin
         r_err <= 1'b1;
      end
   end

   // Write-port mux register: accumulate writes win; otherwise a sweep issue
   // writes zero to the current tile/bin of the active bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_en   <= 1'b0;
         r_mem_num  <= 2'd0;
         r_mem_tile <= '0;
         r_mem_bin  <= '0;
         r_mem_dat  <= '0;
      end else if (wr_req_i) begin
         r_mem_en   <= 1'b1;
         r_mem_num  <= wr_num_i;
         r_mem_tile <= wr_tile_i;
         r_mem_bin  <= wr_bin_i;
         r_mem_dat  <= wr_dat_i;
      end else if (w_issue) begin
         r_mem_en   <= 1'b1;
         r_mem_num  <= r_act_num;
         r_mem_tile <= r_tile_cnt;
         r_mem_bin  <= r_bin_cnt;
         r_mem_dat  <= '0;
      end else begin
         r_mem_en <= 1'b0;
      end
   end

`ifdef CHE_HIST_CLR_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Count CLR cycles lost to accumulate traffic; restart at every sweep start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if (w_start) begin
         r_stall_cnt <= 16'd0;
      end else if ((r_state == ST_CLR) && wr_req_i && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = 16'd0;
`endif

   assign clr_busy_o    = (r_state != ST_IDLE) || r_pend_vld;
   assign clr_done_o    = r_done;
   assign err_o         = r_err;
   assign mem_wr_en_o   = r_mem_en;
   assign mem_wr_num_o  = r_mem_num;
   assign mem_wr_tile_o = r_mem_tile;
   assign mem_wr_bin_o  = r_mem_bin;
   assign mem_wr_dat_o  = r_mem_dat;

endmodule
